sub_bytes_seq: RTL and testbench

Sequential, lane-parametrised SubBytes/InvSubBytes engine for the AES accelerator datapath.
- Accepts a 128-bit state and a direction bit.
- Substitutes LANES bytes per clock, in place, using shared S-box lanes.
- Returns the result over a valid/ready handshake.
- Trades area against latency: LANES=16 gives single-beat substitution; LANES=1 gives the minimum-area build.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/inv_sbox.sv | 9 +
 rtl/sbox.sv | 9 +
 rtl/sbox_lane.sv | 16 +
 rtl/sub_bytes_seq.sv | 102 ++++++++++
 tb/tb_sub_bytes_seq.sv | 244 ++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, S-box mode and FSM types, GF(2^8) S-box helpers
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic {SBOX_FWD = 1'b0, SBOX_INV = 1'b1} sbox_mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} sb_state_e;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; zero maps to zero as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] b;
    r = 8'h01;
    b = a;
    for (int i = 1; i < 8; i++) begin
      b = gf_mul(b, b);
      r = gf_mul(r, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [7:0] v;
    v = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
    return gf_inv(v);
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - inverse AES S-box, one byte
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);
  assign byte_o = sbox_inv(byte_i);
endmodule

// File: rtl/sbox.sv
// rtl/sbox.sv - forward AES S-box, one byte
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);
  assign byte_o = sbox_fwd(byte_i);
endmodule

// File: rtl/sbox_lane.sv
// rtl/sbox_lane.sv - one substitution lane selecting forward or inverse S-box
module sbox_lane
  import aes_pkg::*;
(
  input  sbox_mode_e mode,
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);
  logic [7:0] fwd_byte;
  logic [7:0] inv_byte;

  sbox     u_fwd (.byte_i(byte_i), .byte_o(fwd_byte));
  inv_sbox u_inv (.byte_i(byte_i), .byte_o(inv_byte));

  assign byte_o = (mode == SBOX_INV) ? inv_byte : fwd_byte;
endmodule

// File: rtl/sub_bytes_seq.sv
// rtl/sub_bytes_seq.sv - sequential SubBytes/InvSubBytes engine, LANES bytes per clock
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   mode_i,
  input  logic [AES_BLOCK_W-1:0] data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [AES_BLOCK_W-1:0] data_o,
  output logic                   busy_o
);
  localparam int BEATS = AES_BYTES / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WIN_W = 8 * LANES;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  sb_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  sbox_mode_e            mode_q;
  logic [AES_BLOCK_W-1:0] st_q;
  logic [6:0]            win_lsb;
  logic [WIN_W-1:0]      win_in, win_out;
  logic                  last_beat, accept;

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign accept    = valid_i & ready_o & ~clear_i;
  assign win_lsb   = 7'(32'(cnt_q) * WIN_W);
  assign win_in    = st_q[win_lsb +: WIN_W];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_lane u_lane (
      .mode   (mode_q),
      .byte_i (win_in[8*i +: 8]),
      .byte_o (win_out[8*i +: 8])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (valid_i) state_d = ST_BUSY;
        ST_BUSY: if (last_beat) state_d = ST_DONE;
        ST_DONE: if (ready_i) state_d = valid_i ? ST_BUSY : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    busy_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: ready_o = 1'b1;
      ST_BUSY: busy_o  = 1'b1;
      ST_DONE: begin
        valid_o = 1'b1;
        ready_o = ready_i;
      end
      default: ;
    endcase
  end

  // Clear only rewinds the counter; the stale state is never presented again
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= '0;
      cnt_q  <= '0;
      mode_q <= SBOX_FWD;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      st_q   <= data_i;
      mode_q <= sbox_mode_e'(mode_i);
      cnt_q  <= '0;
    end else if (state_q == ST_BUSY) begin
      st_q[win_lsb +: WIN_W] <= win_out;
      cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
    end
  end

  assign data_o = st_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// tb/tb_sub_bytes_seq.sv - self-checking bench for sub_bytes_seq across all lane counts
module tb_sub_bytes_seq;
  localparam int N = 5;
  localparam logic [127:0] V2 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] R2 = 128'h76abd7fe2b670130c56f6bf27b777c63;

  logic clk = 1'b0;
  logic rst_n;
  logic clr [N];
  logic vi  [N];
  logic md  [N];
  logic ri  [N];
  logic ro  [N];
  logic vo  [N];
  logic bo  [N];
  logic [127:0] di   [N];
  logic [127:0] dout [N];
  bit   done [N];
  bit   go, ph3;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int lanes, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lanes=%0d got %h want %h", nm, lanes, act, exp);
    end
  endtask

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Table built by walking generator 3 and its inverse, independent of any GF inversion
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] sub_block(input logic [127:0] d, input logic m);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = m ? isb[d[8*k +: 8]] : sb[d[8*k +: 8]];
    return r;
  endfunction

  function automatic bit all_done();
    for (int k = 0; k < N; k++) if (!done[k]) return 1'b0;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < N; g++) begin : gi
    localparam int L = 1 << g;
    localparam int BEATS = 16 / L;

    sub_bytes_seq #(.LANES(L)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[g]), .valid_i(vi[g]), .ready_o(ro[g]),
      .mode_i(md[g]), .data_i(di[g]), .valid_o(vo[g]), .ready_i(ri[g]),
      .data_o(dout[g]), .busy_o(bo[g])
    );

    task automatic send(input logic [127:0] d, input logic m, output int acc);
      di[g] = d; md[g] = m; vi[g] = 1'b1; acc = -1;
      for (int k = 0; k < 64 && acc < 0; k++) begin
        #2;
        if (ro[g]) acc = cyc + 1;
        @(negedge clk);
      end
      vi[g] = 1'b0;
      chk("accept_seen", L, 128'(acc >= 0), 128'd1);
    endtask

    task automatic wait_valid(input int acc, output logic [127:0] res);
      int seen;
      seen = -1;
      res = '0;
      for (int k = 0; k < 64 && seen < 0; k++) begin
        #2;
        if (vo[g]) begin seen = cyc; res = dout[g]; end
        @(negedge clk);
      end
      chk("latency", L, 128'(seen - acc), 128'(BEATS));
    endtask

    initial begin : drv
      int a, seen;
      logic acc_last;
      logic [127:0] r, r2;
      wait (go);
      @(negedge clk);
      ri[g] = 1'b1;
      send(V2, 1'b0, a); wait_valid(a, r);
      chk("fwd_vec", L, r, R2);
      chk("fwd_byte0", L, 128'(r[7:0]), 128'h63);
      chk("fwd_byte1", L, 128'(r[15:8]), 128'h7c);
      chk("fwd_byte15", L, 128'(r[127:120]), 128'h76);
      send(r, 1'b1, a); wait_valid(a, r2);
      chk("inv_roundtrip", L, r2, V2);
      send({16{8'h63}}, 1'b1, a); wait_valid(a, r2);
      chk("inv_all63", L, r2, '0);
      ri[g] = 1'b0;
      send(128'h00112233445566778899aabbccddeeff, 1'b0, a); wait_valid(a, r);
      vi[g] = 1'b1; di[g] = 128'hdeadbeef0123456789abcdeffedcba98; md[g] = 1'b1;
      repeat (6) begin
        #2;
        chk("bp_valid", L, 128'(vo[g]), 128'd1);
        chk("bp_data", L, dout[g], sub_block(128'h00112233445566778899aabbccddeeff, 1'b0));
        chk("bp_ready", L, 128'(ro[g]), 128'd0);
        @(negedge clk);
      end
      ri[g] = 1'b1;
      #2;
      chk("bp_ready_rise", L, 128'(ro[g]), 128'd1);
      a = cyc + 1;
      @(negedge clk);
      vi[g] = 1'b0;
      wait_valid(a, r2);
      chk("bp_next", L, r2, sub_block(128'hdeadbeef0123456789abcdeffedcba98, 1'b1));
      send(V2, 1'b0, a);
      repeat ((BEATS > 2) ? 2 : BEATS - 1) @(negedge clk);
      clr[g] = 1'b1;
      @(negedge clk);
      clr[g] = 1'b0;
      #2;
      chk("abort_ready", L, 128'(ro[g]), 128'd1);
      chk("abort_idle", L, 128'(bo[g]), 128'd0);
      seen = 0;
      repeat (20) begin
        @(negedge clk); #2;
        if (vo[g]) seen = 1;
      end
      chk("abort_no_valid", L, 128'(seen), 128'd0);
      @(negedge clk);
      acc_last = 1'b0;
      repeat (300) begin
        clr[g] = ($urandom_range(0, 49) == 0);
        ri[g]  = ($urandom_range(0, 3) != 0);
        if (!vi[g] || acc_last) begin
          vi[g] = $urandom_range(0, 1) == 1;
          di[g] = {$urandom(), $urandom(), $urandom(), $urandom()};
          md[g] = $urandom_range(0, 1) == 1;
        end
        #2;
        acc_last = vi[g] && ro[g] && !clr[g];
        @(negedge clk);
      end
      vi[g] = 1'b0; ri[g] = 1'b1; clr[g] = 1'b0;
      repeat (40) @(negedge clk);
      done[g] = 1'b1;
      wait (ph3);
      @(negedge clk);
      di[g] = V2; md[g] = 1'b0; vi[g] = 1'b1;
      @(negedge clk);
      vi[g] = 1'b0;
    end

    // Model: a held block becomes visible BEATS edges after its accept edge
    initial begin : cmp
      logic has, ev, eb, er;
      int rem;
      logic [127:0] exp;
      has = 1'b0; rem = 0; exp = '0;
      forever begin
        @(negedge clk); #1;
        if (!rst_n) begin
          has = 1'b0; rem = 0;
          chk("rst_valid", L, 128'(vo[g]), 128'd0);
          chk("rst_busy", L, 128'(bo[g]), 128'd0);
          chk("rst_ready", L, 128'(ro[g]), 128'd1);
          chk("rst_data", L, dout[g], '0);
        end else begin
          ev = has && rem == 0;
          eb = has && rem > 0;
          er = !has || (ev && ri[g]);
          chk("valid", L, 128'(vo[g]), 128'(ev));
          chk("busy", L, 128'(bo[g]), 128'(eb));
          chk("ready", L, 128'(ro[g]), 128'(er));
          if (ev) chk("data", L, dout[g], exp);
          if (clr[g]) begin
            has = 1'b0;
          end else begin
            if (eb) rem--;
            else if (ev && ri[g]) has = 1'b0;
            if (vi[g] && er) begin
              has = 1'b1; rem = BEATS; exp = sub_block(di[g], md[g]);
            end
          end
        end
      end
    end
  end

  initial begin
    build_tables();
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      clr[k] = 1'b0; vi[k] = 1'b0; md[k] = 1'b0; ri[k] = 1'b1; di[k] = '0;
    end
    chk("model_fwd_vec", 0, sub_block(V2, 1'b0), R2);
    chk("model_s53", 0, 128'(sb[8'h53]), 128'hed);
    chk("model_inv_ed", 0, 128'(isb[8'hed]), 128'h53);
    chk("model_inv_63", 0, 128'(isb[8'h63]), 128'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    go = 1'b1;
    for (int t = 0; t < 30000 && !all_done(); t++) @(negedge clk);
    chk("phase_timeout", 0, 128'(all_done()), 128'd1);
    repeat (5) @(negedge clk);
    ph3 = 1'b1;
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("async_rst_valid", 1 << k, 128'(vo[k]), 128'd0);
      chk("async_rst_busy", 1 << k, 128'(bo[k]), 128'd0);
      chk("async_rst_ready", 1 << k, 128'(ro[k]), 128'd1);
      chk("async_rst_data", 1 << k, dout[k], '0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
